// File: rtl/frame_stream_gen.sv
// Multi-channel raster stream source: shared H/V scan, per-channel line offset,
// 1-cycle-latency frame memory reads, registered outputs two cycles after the read.
// Optional test-pattern data source is enabled by `define FRAME_STREAM_PATTERN_EN.
module frame_stream_gen #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned DATA_BW   = 8,
  parameter int unsigned DEPTH_BW  = 16,
  parameter int unsigned H_SIZE_BW = 10,
  parameter int unsigned V_SIZE_BW = 9,
  parameter int unsigned ADDR_BW   = 19
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_start,
  input  logic                             i_abort,
  input  logic [H_SIZE_BW-1:0]             r_hsize,
  input  logic [V_SIZE_BW-1:0]             r_vsize,
  input  logic [H_SIZE_BW-1:0]             r_hblank,
  input  logic [V_SIZE_BW-1:0]             r_vblank,
  input  logic                             r_continuous,
  input  logic [NUM_CH-1:0][V_SIZE_BW-1:0] r_ch_delay,
`ifdef FRAME_STREAM_PATTERN_EN
  input  logic                             r_pattern,
`endif
  output logic [NUM_CH-1:0]                o_rd_en,
  output logic [NUM_CH-1:0][ADDR_BW-1:0]   o_rd_addr,
  input  logic [NUM_CH-1:0][DATA_BW-1:0]   i_rd_pixel,
  input  logic [NUM_CH-1:0][DEPTH_BW-1:0]  i_rd_depth,
  output logic [NUM_CH-1:0]                o_valid,
  output logic [NUM_CH-1:0]                o_frame_start,
  output logic [NUM_CH-1:0]                o_frame_end,
  output logic [NUM_CH-1:0][DATA_BW-1:0]   o_pixel,
  output logic [NUM_CH-1:0][DEPTH_BW-1:0]  o_depth,
  output logic [NUM_CH-1:0][H_SIZE_BW-1:0] o_x,
  output logic [NUM_CH-1:0][V_SIZE_BW-1:0] o_y,
  output logic                             o_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SCAN, ST_DONE} state_t;

  state_t state     [NUM_CH];
  state_t state_nxt [NUM_CH];

  logic [H_SIZE_BW-1:0]             cfg_hsize, cfg_hblank, h_last, hsize_m1;
  logic [V_SIZE_BW-1:0]             cfg_vsize, cfg_vblank, v_last, vsize_m1;
  logic                             cfg_cont, cfg_pattern;
  logic [NUM_CH-1:0][V_SIZE_BW-1:0] cfg_delay;

  logic [H_SIZE_BW-1:0]             hcnt;
  logic [V_SIZE_BW-1:0]             gl;
  logic                             start_acc, any_busy, all_done, any_run, gl_wrap;

  logic [NUM_CH-1:0][H_SIZE_BW-1:0] cx;
  logic [NUM_CH-1:0][V_SIZE_BW-1:0] cy;
  logic [NUM_CH-1:0][ADDR_BW-1:0]   addr;
  logic [NUM_CH-1:0]                active, frame_last, first_px, last_px;

  logic [NUM_CH-1:0]                s1_valid, s1_first, s1_last, s2_last;
  logic [NUM_CH-1:0][H_SIZE_BW-1:0] s1_x;
  logic [NUM_CH-1:0][V_SIZE_BW-1:0] s1_y;
  logic [NUM_CH-1:0][DATA_BW-1:0]   pat_pix;
  logic [NUM_CH-1:0][DEPTH_BW-1:0]  pat_depth;

  assign h_last   = cfg_hsize + cfg_hblank - H_SIZE_BW'(1);
  assign v_last   = cfg_vsize + cfg_vblank - V_SIZE_BW'(1);
  assign hsize_m1 = cfg_hsize - H_SIZE_BW'(1);
  assign vsize_m1 = cfg_vsize - V_SIZE_BW'(1);
  assign gl_wrap  = (hcnt == h_last);

  always_comb begin
    any_busy = 1'b0;
    all_done = 1'b1;
    any_run  = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (state[c] != ST_IDLE) any_busy = 1'b1;
      if (state[c] != ST_DONE) all_done = 1'b0;
      if (state[c] == ST_WAIT || state[c] == ST_SCAN) any_run = 1'b1;
    end
  end

  assign start_acc = i_start && !i_abort && !any_busy;
  assign o_busy    = any_busy;
  assign o_rd_addr = addr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cfg_hsize  <= '0;
      cfg_vsize  <= '0;
      cfg_hblank <= '0;
      cfg_vblank <= '0;
      cfg_cont   <= 1'b0;
      cfg_delay  <= '0;
    end else if (start_acc) begin
      cfg_hsize  <= r_hsize;
      cfg_vsize  <= r_vsize;
      cfg_hblank <= r_hblank;
      cfg_vblank <= r_vblank;
      cfg_cont   <= r_continuous;
      cfg_delay  <= r_ch_delay;
    end
  end

`ifdef FRAME_STREAM_PATTERN_EN
  always_ff @(posedge i_clk) begin
    if (i_rst)          cfg_pattern <= 1'b0;
    else if (start_acc) cfg_pattern <= r_pattern;
  end
`else
  assign cfg_pattern = 1'b0;
`endif

  // Global line counter runs only while some channel still waits or scans.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_abort || start_acc) begin
      hcnt <= '0;
      gl   <= '0;
    end else if (any_run) begin
      if (gl_wrap) begin
        hcnt <= '0;
        gl   <= gl + V_SIZE_BW'(1);
      end else begin
        hcnt <= hcnt + H_SIZE_BW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int unsigned c = 0; c < NUM_CH; c++)
      state[c] <= i_rst ? ST_IDLE : state_nxt[c];
  end

  // Delay-0 channels skip WAIT; others enter SCAN as gl steps onto their delay,
  // so every channel starts exactly on a global line boundary.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      state_nxt[c] = state[c];
      if (i_abort) begin
        state_nxt[c] = ST_IDLE;
      end else begin
        case (state[c])
          ST_IDLE: if (start_acc) state_nxt[c] = (r_ch_delay[c] == '0) ? ST_SCAN : ST_WAIT;
          ST_WAIT: if (gl_wrap && (gl + V_SIZE_BW'(1)) == cfg_delay[c]) state_nxt[c] = ST_SCAN;
          ST_SCAN: if (frame_last[c] && !cfg_cont) state_nxt[c] = ST_DONE;
          ST_DONE: if (all_done) state_nxt[c] = ST_IDLE;
          default: state_nxt[c] = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    active     = '0;
    frame_last = '0;
    first_px   = '0;
    last_px    = '0;
    o_rd_en    = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      active[c]     = (state[c] == ST_SCAN) && (cx[c] < cfg_hsize) && (cy[c] < cfg_vsize);
      frame_last[c] = (state[c] == ST_SCAN) && (cx[c] == h_last) && (cy[c] == v_last);
      first_px[c]   = active[c] && (cx[c] == '0) && (cy[c] == '0);
      last_px[c]    = active[c] && (cx[c] == hsize_m1) && (cy[c] == vsize_m1);
      o_rd_en[c]    = active[c] && !cfg_pattern;
    end
  end

  // Counters sit at zero outside SCAN, so frame entry needs no explicit clear.
  always_ff @(posedge i_clk) begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (i_rst || i_abort || state[c] != ST_SCAN || frame_last[c]) begin
        cx[c]   <= '0;
        cy[c]   <= '0;
        addr[c] <= '0;
      end else begin
        if (cx[c] == h_last) begin
          cx[c] <= '0;
          cy[c] <= cy[c] + V_SIZE_BW'(1);
        end else begin
          cx[c] <= cx[c] + H_SIZE_BW'(1);
        end
        if (active[c]) addr[c] <= addr[c] + ADDR_BW'(1);
      end
    end
  end

  always_comb begin
    pat_pix   = '0;
    pat_depth = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      pat_pix[c]   = DATA_BW'(8'(s1_x[c]) ^ 8'(s1_y[c]));
      pat_depth[c] = DEPTH_BW'({s1_y[c], s1_x[c]});
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_abort) begin
      s1_valid      <= '0;
      s1_first      <= '0;
      s1_last       <= '0;
      s1_x          <= '0;
      s1_y          <= '0;
      s2_last       <= '0;
      o_valid       <= '0;
      o_frame_start <= '0;
      o_frame_end   <= '0;
      o_pixel       <= '0;
      o_depth       <= '0;
      o_x           <= '0;
      o_y           <= '0;
    end else begin
      s1_valid      <= active;
      s1_first      <= first_px;
      s1_last       <= last_px;
      s1_x          <= cx;
      s1_y          <= cy;
      s2_last       <= s1_last;
      o_valid       <= s1_valid;
      o_frame_start <= s1_valid & s1_first;
      o_frame_end   <= s2_last;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (s1_valid[c]) begin
          o_x[c]     <= s1_x[c];
          o_y[c]     <= s1_y[c];
          o_pixel[c] <= cfg_pattern ? pat_pix[c]   : i_rd_pixel[c];
          o_depth[c] <= cfg_pattern ? pat_depth[c] : i_rd_depth[c];
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_stream_gen.sv
// Scoreboard bench for frame_stream_gen: a raster model pushes timestamped beats
// per channel when a sequence is started; a negedge monitor pops and compares.
module tb_frame_stream_gen;
  localparam int NCH = 2, DBW = 8, ZBW = 16, HBW = 10, VBW = 9, ABW = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       rst, start, abort, cont;
  logic [HBW-1:0]             hsize, hblank;
  logic [VBW-1:0]             vsize, vblank;
  logic [NCH-1:0][VBW-1:0]    ch_delay;
`ifdef FRAME_STREAM_PATTERN_EN
  logic                       pattern;
`endif
  logic [NCH-1:0]             rd_en, valid, fstart, fend;
  logic [NCH-1:0][ABW-1:0]    rd_addr;
  logic [NCH-1:0][DBW-1:0]    rd_pixel = '0, pixel;
  logic [NCH-1:0][ZBW-1:0]    rd_depth = '0, depth;
  logic [NCH-1:0][HBW-1:0]    ox;
  logic [NCH-1:0][VBW-1:0]    oy;
  logic                       busy;

  frame_stream_gen #(
    .NUM_CH(NCH), .DATA_BW(DBW), .DEPTH_BW(ZBW),
    .H_SIZE_BW(HBW), .V_SIZE_BW(VBW), .ADDR_BW(ABW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .r_hsize(hsize), .r_vsize(vsize), .r_hblank(hblank), .r_vblank(vblank),
    .r_continuous(cont), .r_ch_delay(ch_delay),
`ifdef FRAME_STREAM_PATTERN_EN
    .r_pattern(pattern),
`endif
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_pixel(rd_pixel), .i_rd_depth(rd_depth),
    .o_valid(valid), .o_frame_start(fstart), .o_frame_end(fend),
    .o_pixel(pixel), .o_depth(depth), .o_x(ox), .o_y(oy), .o_busy(busy)
  );

  typedef struct { int t; logic [43:0] d; } beat_t;
  beat_t beat_q [NCH][$];
  int    fe_q   [NCH][$];
  int    rd_cnt [NCH];
  int    cyc = 0;
  int    n_tests = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DBW-1:0] mem_pix(input int c, input int a);
    return DBW'(a * 7 + c * 29 + 3);
  endfunction
  function automatic logic [ZBW-1:0] mem_dep(input int c, input int a);
    return ZBW'(a * 131 + c * 1000 + 11);
  endfunction

  // Frame memory with one cycle of read latency.
  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (rd_en[c]) begin
        rd_pixel[c] <= mem_pix(c, int'(rd_addr[c]));
        rd_depth[c] <= mem_dep(c, int'(rd_addr[c]));
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial for (int c = 0; c < NCH; c++) rd_cnt[c] = 0;

  always @(negedge clk) begin
    beat_t mb;
    for (int c = 0; c < NCH; c++) begin
      if (rd_en[c] === 1'b1) rd_cnt[c]++;
      if (valid[c] === 1'b1) begin
        if (beat_q[c].size() == 0) begin
          chk("extra_valid", 64'(valid[c]), 64'd0);
        end else begin
          mb = beat_q[c].pop_front();
          chk("valid_time", 64'(cyc), 64'(mb.t));
          chk("beat_xy_data_fs", 64'({ox[c], oy[c], pixel[c], depth[c], fstart[c]}), 64'(mb.d));
        end
      end else if (fstart[c] === 1'b1) begin
        chk("fs_without_valid", 64'(fstart[c]), 64'd0);
      end
      if (fend[c] === 1'b1) begin
        if (fe_q[c].size() == 0) chk("extra_frame_end", 64'(fend[c]), 64'd0);
        else chk("frame_end_time", 64'(cyc), 64'(fe_q[c].pop_front()));
      end
    end
  end

  // kill_rel > 0: abort (or reset if kill_rst) is asserted kill_rel cycles after start.
  // dup_rel > 0: a second start pulse is driven that many cycles after start.
  task automatic run(input int hs, input int vs, input int hb, input int vb, input int cnt,
                     input int d0, input int d1, input int pat,
                     input int kill_rel, input int kill_rst, input int dup_rel);
    int s, cut, L, F, dmax, drop, base, last_t, rel, t, a, d;
    int rd_base [NCH];
    beat_t b;
    logic [7:0]  pp8;
    logic [DBW-1:0] pp;
    logic [ZBW-1:0] dd;
    @(negedge clk);
    hsize = HBW'(hs); vsize = VBW'(vs); hblank = HBW'(hb); vblank = VBW'(vb);
    cont = cnt[0]; ch_delay[0] = VBW'(d0); ch_delay[1] = VBW'(d1);
`ifdef FRAME_STREAM_PATTERN_EN
    pattern = pat[0];
`endif
    start = 1'b1;
    s = cyc;
    L = hs + hb; F = vs + vb; dmax = (d0 > d1) ? d0 : d1;
    cut = (kill_rel > 0) ? s + kill_rel : 32'h3fff_ffff;
    for (int c = 0; c < NCH; c++) begin
      rd_base[c] = rd_cnt[c];
      d = (c == 0) ? d0 : d1;
      for (int f = 0; f == 0 || cnt != 0; f++) begin
        base = s + 3 + (d + f * F) * L;
        if (base > cut) break;
        last_t = -1;
        for (int y = 0; y < vs; y++) begin
          for (int x = 0; x < hs; x++) begin
            t = base + y * L + x;
            a = y * hs + x;
            if (pat != 0) begin
              pp8 = 8'(x ^ y);
              pp  = DBW'(pp8);
              dd  = ZBW'((y << 10) | x);
            end else begin
              pp = mem_pix(c, a);
              dd = mem_dep(c, a);
            end
            b.t = t;
            b.d = {HBW'(x), VBW'(y), pp, dd, (x == 0 && y == 0)};
            if (t <= cut) beat_q[c].push_back(b);
            last_t = t;
          end
        end
        if (last_t >= 0 && last_t + 1 <= cut) fe_q[c].push_back(last_t + 1);
      end
    end
    drop = s + 2 + (dmax + F) * L;
    forever begin
      @(negedge clk);
      rel = cyc - s;
      start = (rel == dup_rel);
      if (rel == 2) begin
        hsize = hsize + HBW'(3); vsize = vsize + VBW'(1); hblank = hblank + HBW'(1);
        vblank = vblank + VBW'(2); cont = ~cont; ch_delay = ~ch_delay;
      end
      if (kill_rel > 0) begin
        if (rel == kill_rel) begin
          if (kill_rst != 0) rst = 1'b1; else abort = 1'b1;
        end
        if (rel == kill_rel + 1) begin
          rst = 1'b0; abort = 1'b0;
          chk("busy_after_kill", 64'(busy), 64'd0);
          chk("valid_after_kill", 64'(valid), 64'd0);
        end
        if (rel == kill_rel + 8) break;
      end else begin
        if (rel == drop - s - 1) chk("busy_before_drop", 64'(busy), 64'd1);
        if (rel == drop - s)     chk("busy_drop", 64'(busy), 64'd0);
        if (rel == drop - s + 4) break;
      end
      if (rel > 4000) begin
        chk("timeout_busy", 64'(busy), 64'd0);
        break;
      end
    end
    for (int c = 0; c < NCH; c++) begin
      chk("beats_missing", 64'(beat_q[c].size()), 64'd0);
      chk("frame_end_missing", 64'(fe_q[c].size()), 64'd0);
      if (kill_rel == 0) chk("rd_en_count", 64'(rd_cnt[c] - rd_base[c]), 64'((pat != 0) ? 0 : hs * vs));
      beat_q[c].delete();
      fe_q[c].delete();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; cont = 1'b0;
    hsize = '0; vsize = '0; hblank = '0; vblank = '0; ch_delay = '0;
`ifdef FRAME_STREAM_PATTERN_EN
    pattern = 1'b0;
`endif
    repeat (4) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_fs_fe", 64'({fstart, fend}), 64'd0);
    chk("rst_pixel", 64'(pixel), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    rst = 1'b0;
    //  hs vs hb vb cnt d0 d1 pat kill rst dup
    run(4, 2, 2, 1, 0, 0, 0, 0, 0, 0, 0);   // basic timing
    run(4, 2, 2, 1, 0, 0, 1, 0, 0, 0, 0);   // channel offset
    run(3, 2, 0, 0, 1, 0, 0, 0, 22, 0, 0);  // back-to-back continuous, then abort
    run(4, 2, 2, 1, 0, 0, 0, 0, 5, 0, 0);   // abort at third valid
    run(4, 2, 2, 1, 0, 0, 0, 0, 0, 0, 0);   // restart after abort
    run(4, 2, 2, 1, 0, 0, 0, 0, 0, 0, 6);   // start while busy
    run(0, 2, 2, 1, 0, 0, 0, 0, 0, 0, 0);   // zero active width
    run(4, 2, 0, 1, 0, 0, 1, 0, 0, 0, 0);   // no horizontal blank
    run(5, 3, 1, 2, 0, 2, 0, 0, 0, 0, 0);   // odd shape, reversed offset
    run(4, 2, 2, 1, 0, 1, 0, 0, 9, 1, 0);   // reset mid-frame
    run(4, 2, 2, 1, 0, 0, 0, 0, 0, 0, 0);   // clean run after reset
`ifdef FRAME_STREAM_PATTERN_EN
    run(4, 2, 2, 1, 0, 0, 0, 1, 0, 0, 0);   // pattern source
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
